// File: rtl/cache_arbiter_pkg.sv
// Shared types and helpers for the cache lookup-port arbiter.
package cache_arbiter_pkg;

  // Arbiter FSM states, in transaction order.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

  // Width of a requester index. A single requester still needs one bit
  // so that index vectors never collapse to zero width.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: the first set bit of req, starting at
// ptr and wrapping modulo N. N need not be a power of two, so the wrap is
// an explicit compare-and-subtract rather than natural index overflow.
module rr_priority_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  // Walk the N candidates in priority order; the first hit wins.
  always_comb begin
    int          idx;
    logic [W-1:0] cand;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = W'(idx);
      if (!any && req[cand]) begin
        grant_idx = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache lookup port among NUM_REQ
// requesters. One transaction at a time: grant, issue the address, capture
// the cache word, deliver it to the owner, then rotate priority.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction; arbitrate, pulse req_ready to the winner
//   ISSUE   | cache_addr_valid high, waiting for cache_addr_ready
//   CAPTURE | cache_data is valid this cycle; register it
//   DELIVER | resp_valid to the owner until it asserts its resp_ready
module cache_port_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DWIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DWIDTH-1:0]             resp_data,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic                          cache_addr_valid,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  input  logic                          cache_addr_ready,
  input  logic [DWIDTH-1:0]             cache_data,
  output logic                          busy
);

  localparam int PW = ptr_width(NUM_REQ);

  arb_state_t            state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         ptr_next;
  logic [PW-1:0]         sel_idx;
  logic                  sel_any;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    grant_onehot;

  rr_priority_select #(
    .N (NUM_REQ),
    .W (PW)
  ) u_rr_sel (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant_idx (sel_idx),
    .any       (sel_any)
  );

  // Unpack the flattened address bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // One-hot form of the locked grant, used to drive resp_valid.
  always_comb begin
    grant_onehot        = '0;
    grant_onehot[grant] = 1'b1;
  end

  // Priority rotates to the requester after the one just served.
  assign ptr_next = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // req_ready is a same-cycle pulse in IDLE only, so a requester sees the
  // take in the very cycle it is arbitrated; held low while in reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && sel_any && !reset) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Transaction FSM with its address, grant and data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      grant            <= '0;
      cache_addr       <= '0;
      cache_addr_valid <= 1'b0;
      resp_valid       <= '0;
      resp_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant            <= sel_idx;
            cache_addr       <= addr_arr[sel_idx];
            cache_addr_valid <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          // A cache miss just stretches this state; there is no timeout.
          if (cache_addr_ready) begin
            cache_addr_valid <= 1'b0;
            state            <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The cache drives data_out the cycle after addr_in_ready.
          resp_data  <= cache_data;
          resp_valid <= grant_onehot;
          state      <= DELIVER;
        end
        DELIVER: begin
          // Only the owner's acceptance ends the transaction.
          if (resp_ready[grant]) begin
            resp_valid <= '0;
            rr_ptr     <= ptr_next;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a small behavioural cache on
// the lookup port. Hit = ready one cycle after valid; miss adds
// miss_cycles extra wait cycles. Word for address a is a ^ 16'hA5A5,
// except 16'hDEAD which holds 16'hBEEF.
module tb_cache_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_data;
  logic [NR-1:0]    resp_ready;
  logic             cache_addr_valid;
  logic [AW-1:0]    cache_addr;
  logic             cache_addr_ready;
  logic [DW-1:0]    cache_data;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int miss_cycles = 0;
  int cnt;

  cache_port_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DWIDTH     (DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_ready       (resp_ready),
    .cache_addr_valid (cache_addr_valid),
    .cache_addr       (cache_addr),
    .cache_addr_ready (cache_addr_ready),
    .cache_data       (cache_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'hDEAD) return 16'hBEEF;
    return a ^ 16'hA5A5;
  endfunction

  // Behavioural cache lookup port.
  always @(posedge clk) begin
    if (reset) begin
      cache_addr_ready <= 1'b0;
      cache_data       <= '0;
      cnt              <= 0;
    end else begin
      if (cache_addr_valid && !cache_addr_ready) begin
        if (cnt >= miss_cycles) begin
          cache_addr_ready <= 1'b1;
          cnt              <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cache_addr_ready <= 1'b0;
      end
      if (cache_addr_valid && cache_addr_ready) begin
        cache_data <= mem_word(cache_addr);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [15:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Poll at negedges for a response (bounded), then check owner and data.
  task automatic wait_resp(input string tag, input logic [3:0] exp_vld,
                           input logic [15:0] exp_data, output int lat);
    lat = 0;
    while (resp_valid == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_vld"}, resp_valid, exp_vld);
    check_eq({tag, "_data"}, resp_data, exp_data);
  endtask

  // Called at an IDLE-cycle negedge with requests already driven; expects
  // a hit transaction and returns at the following IDLE-cycle negedge.
  task automatic serve(input string tag, input int idx, input logic [15:0] exp_data);
    int lat;
    #1;
    check_eq({tag, "_rdy"}, req_ready, 4'b0001 << idx);
    wait_resp(tag, 4'b0001 << idx, exp_data, lat);
    check_eq({tag, "_lat"}, lat, 4);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;
    reset      = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    resp_ready = 4'hF;
    do_reset();

    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_addr_valid", cache_addr_valid, 0);
    check_eq("rst_addr", cache_addr, 0);
    repeat (30) @(negedge clk);

    // Single miss, then the same address as a hit.
    set_addr(2, 16'hDEAD);
    req_valid   = 4'b0100;
    miss_cycles = 3;
    #1;
    check_eq("miss_rdy", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_eq("miss_rdy_once", req_ready, 0);
    check_eq("miss_issue_vld", cache_addr_valid, 1);
    check_eq("miss_issue_addr", cache_addr, 16'hDEAD);
    check_eq("miss_busy", busy, 1);
    wait_resp("miss", 4'b0100, 16'hBEEF, lat);
    check_eq("miss_lat", lat + 1, 7);
    @(negedge clk);
    check_eq("miss_idle", busy, 0);
    miss_cycles = 0;
    req_valid   = 4'b0100;
    serve("hit", 2, 16'hBEEF);
    req_valid = '0;

    // Round-robin from a fresh pointer, then wrap with only 0 and 3 valid.
    do_reset();
    set_addr(0, 16'h0100);
    set_addr(1, 16'h0204);
    set_addr(2, 16'h0308);
    set_addr(3, 16'h040C);
    req_valid = 4'hF;
    serve("rr0", 0, 16'hA4A5);
    serve("rr1", 1, 16'hA7A1);
    serve("rr2", 2, 16'hA6AD);
    serve("rr3", 3, 16'hA1A9);
    req_valid = 4'b1001;
    serve("wrap0", 0, 16'hA4A5);
    serve("wrap3", 3, 16'hA1A9);
    req_valid = '0;

    // Response backpressure on requester 1 for 10 cycles.
    set_addr(1, 16'h1234);
    req_valid  = 4'b0010;
    resp_ready = 4'b1101;
    #1;
    check_eq("bp_rdy", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_resp("bp", 4'b0010, 16'hB791, lat);
    set_addr(0, 16'h0ABC);
    req_valid   = 4'b0001;
    miss_cycles = 2;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid !== 4'b0010 || resp_data !== 16'hB791 ||
          req_ready !== 4'b0000 || busy !== 1'b1) bad++;
    end
    check_eq("bp_stable", bad, 0);
    resp_ready = 4'hF;
    @(negedge clk);
    check_eq("bp_release_idle", busy, 0);

    // Requester 0 drops valid and changes address right after its grant.
    #1;
    check_eq("drop_rdy", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    set_addr(0, 16'hFFFF);
    #1;
    check_eq("drop_addr_a", cache_addr, 16'h0ABC);
    @(negedge clk);
    #1;
    check_eq("drop_addr_b", cache_addr, 16'h0ABC);
    check_eq("drop_addr_vld", cache_addr_valid, 1);
    wait_resp("drop", 4'b0001, 16'hAF19, lat);
    @(negedge clk);

    // Move the pointer to 3, then reset during a miss.
    miss_cycles = 0;
    set_addr(2, 16'h2222);
    req_valid = 4'b0100;
    serve("pre_rst", 2, 16'h8787);
    req_valid   = '0;
    miss_cycles = 10;
    set_addr(2, 16'h5555);
    req_valid = 4'b0100;
    #1;
    check_eq("mid_rdy", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check_eq("mid_issue", cache_addr_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_addr_vld", cache_addr_valid, 0);
    check_eq("mid_rst_addr", cache_addr, 0);
    check_eq("mid_rst_req_ready", req_ready, 0);
    check_eq("mid_rst_resp_valid", resp_valid, 0);
    check_eq("mid_rst_resp_data", resp_data, 0);
    reset       = 1'b0;
    miss_cycles = 0;
    set_addr(1, 16'h3C3C);
    set_addr(3, 16'h7777);
    serve("post_rst", 1, 16'h9999);
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Round-robin arbiter sharing one `cache_directly_mapped` lookup port among `NUM_REQ` requesters, the matching engines that each fetch instructions. It sits between the requesters and the cache's `addr_in` side. It serialises lookups, locks the grant for the full transaction, captures the cache data, and returns it to the owning requester with a valid/ready handshake. Hit and miss traffic look identical to the arbiter; the cache's refill side is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ADDR_WIDTH`, 16: address width; must match the cache.
- `DWIDTH`, 16: data width; must match the cache.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; shared with the cache.
- `req_valid`  in  NUM_REQ  per-requester request strobe.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot pulse; the request is taken.
- `resp_valid`  out  NUM_REQ  one-hot; response for requester i.
- `resp_data`  out  DWIDTH  response word, shared by all requesters.
- `resp_ready`  in  NUM_REQ  per-requester response acceptance.
- `cache_addr_valid`  out  1  to cache `addr_in_valid`.
- `cache_addr`  out  ADDR_WIDTH  to cache `addr_in`.
- `cache_addr_ready`  in  1  from cache `addr_in_ready`.
- `cache_data`  in  DWIDTH  from cache `data_out`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, CAPTURE, DELIVER.
- **IDLE:**
  - If any `req_valid` is high, pick the winner `g` by round-robin. Search starts at `rr_ptr` and wraps modulo NUM_REQ.
  - Register `g` and `req_addr[g]` into `cache_addr`.
  - Pulse `req_ready[g]` for this cycle, then go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:**
  - `cache_addr_valid` = 1, with `cache_addr` held stable.
  - On `cache_addr_ready` = 1, drop valid next cycle and go to CAPTURE.
  - Wait indefinitely, with no timeout; a miss simply stretches this state.
- **CAPTURE:** register `cache_data` into `resp_data`, then go to DELIVER. The cache presents `data_out` the cycle after `addr_in_ready`.
- **DELIVER:**
  - `resp_valid[g]` = 1, with `resp_data` held.
  - On `resp_ready[g]`: set `rr_ptr` ← (g+1) mod NUM_REQ, then go to IDLE.
  - `resp_ready` of other requesters is ignored.
- **Request changes after grant:** once `req_ready` has pulsed, the address is latched. A requester dropping `req_valid` or changing `req_addr` has no effect on the in-flight access; its response is still delivered and must be accepted.
- **Fairness:** a requester holding `req_valid` is granted within NUM_REQ transactions.
- **Index widths:** `rr_ptr` and `g` are $clog2(NUM_REQ) bits. Wrap is explicit: NUM_REQ need not be a power of two.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, `cache_addr_valid`=0, `cache_addr`=0, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `busy`=0.
- **Reset mid-operation:** any state returns to IDLE the next edge, and the pending transaction is dropped. The cache is reset simultaneously, so no orphan state remains.
- **Hit latency,** with the request seen at cycle t (IDLE):
  - `cache_addr_valid` rises at t+1.
  - Cache ready at t+2, the cache's one-cycle hit.
  - Capture at t+3.
  - `resp_valid` at t+4.
  - With `resp_ready` held, IDLE at t+5.
- **Miss latency:** hit latency plus the cycles `cache_addr_ready` stays low.
- **Throughput:** at most one transaction per 5 cycles; no overlap.
- **Simultaneous events:**
  - Requests arriving in DELIVER are arbitrated in the IDLE cycle that follows; the new `rr_ptr` is already in effect there.
  - `req_ready` never asserts outside IDLE.

## Structure
- **Package `cache_arbiter_pkg`:** the `arb_state_t` enum (IDLE, ISSUE, CAPTURE, DELIVER) and the `ptr_width(n)` function.
- **Sub-module `rr_priority_select`:** combinational round-robin search, (`req` vector, `ptr`) → (`grant_idx`, `any`). It is reused by future DRAM-port arbitration.
- **Top:** FSM, address/grant/data registers, output decode.

## Test plan
All scenarios run with NUM_REQ=4, ADDR_WIDTH=16, DWIDTH=16, after 30-cycle cache warm-up.
- **Single miss then hit:** req 2 sends addr 16'hDEAD; memory returns 16'hBEEF.
  - `req_ready[2]` pulses once.
  - `resp_valid`=4'b0100 with `resp_data`=16'hBEEF.
  - The re-request of 16'hDEAD delivers 16'hBEEF exactly 4 cycles after the request.
- **Round-robin:** all 4 request continuously with distinct hit addresses. Grant order is 0,1,2,3,0, and each `resp_data` matches its address's preloaded word.
- **Pointer wrap:** after req 3 is served, only req 0 and req 3 are valid. The grant goes to 0, then to 3.
- **Response backpressure:** hold `resp_ready[1]` low for 10 cycles. `resp_valid[1]` and `resp_data` stay stable, with no new `req_ready`; 1 cycle after `resp_ready[1]` rises the FSM is back in IDLE.
- **Request dropped after grant:** req 0 deasserts `req_valid` and changes `req_addr` the cycle after `req_ready[0]`. `cache_addr` is unchanged and the response for the original address is still delivered.
- **Reset mid-operation:** assert `reset` in ISSUE during a miss. All outputs are at reset values the next cycle, `rr_ptr`=0, and a subsequent req 1 is granted first.
